// File: rtl/exec_system_mc_if.sv
// exec_system_mc_if: bundles every signal of the SYSTEM execute unit other than
// clk/rst.
//   master : issue stage / CSR file / MMU / writeback side (drives requests and
//            responses into the unit)
//   slave  : the execute unit itself
// Signal groups:
//   issue   in_valid/in_ready, flush, decoded fields, rs1_data, rs2_data
//   arch    privilege_mode, mstatus, mepc, sepc, irq_pending
//   csr     csr_valid/addr/funct3/uimm/wdata out, csr_exception/cause/result in
//   tlb     tlb_flush_req/vaddr/asid out, tlb_flush_ack in
//   result  out_* registered result and xRET side effects
interface exec_system_mc_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic            flush;
  logic [2:0]      funct3;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [6:0]      funct7;
  logic [11:0]     i_imm;
  logic [XLEN-1:0] rs1_data;
  // rs2 register value; only its low 16 bits are used, as the SFENCE.VMA ASID
  logic [XLEN-1:0] rs2_data;
  logic [1:0]      privilege_mode;
  logic [XLEN-1:0] mstatus;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] sepc;
  logic            irq_pending;

  logic            csr_valid;
  logic [11:0]     csr_addr;
  logic [2:0]      csr_funct3;
  logic [4:0]      csr_uimm;
  logic [XLEN-1:0] csr_wdata;
  logic            csr_exception;
  logic [3:0]      csr_cause;
  logic [XLEN-1:0] csr_result;

  logic            tlb_flush_req;
  logic [XLEN-1:0] tlb_flush_vaddr;
  logic [15:0]     tlb_flush_asid;
  logic            tlb_flush_ack;

  logic            out_valid;
  logic            out_exception;
  logic [3:0]      out_trap_cause;
  logic            out_is_xret;
  logic [XLEN-1:0] out_result;
  logic            out_update_mstatus;
  logic [XLEN-1:0] out_new_mstatus;
  logic [1:0]      out_new_priv;

  modport master (
    output in_valid, flush, funct3, rd, rs1, rs2, funct7, i_imm, rs1_data, rs2_data,
           privilege_mode, mstatus, mepc, sepc, irq_pending,
           csr_exception, csr_cause, csr_result, tlb_flush_ack,
    input  in_ready, csr_valid, csr_addr, csr_funct3, csr_uimm, csr_wdata,
           tlb_flush_req, tlb_flush_vaddr, tlb_flush_asid,
           out_valid, out_exception, out_trap_cause, out_is_xret, out_result,
           out_update_mstatus, out_new_mstatus, out_new_priv
  );

  modport slave (
    input  in_valid, flush, funct3, rd, rs1, rs2, funct7, i_imm, rs1_data, rs2_data,
           privilege_mode, mstatus, mepc, sepc, irq_pending,
           csr_exception, csr_cause, csr_result, tlb_flush_ack,
    output in_ready, csr_valid, csr_addr, csr_funct3, csr_uimm, csr_wdata,
           tlb_flush_req, tlb_flush_vaddr, tlb_flush_asid,
           out_valid, out_exception, out_trap_cause, out_is_xret, out_result,
           out_update_mstatus, out_new_mstatus, out_new_priv
  );
endinterface

// File: rtl/exec_system_mc.sv
// exec_system_mc: multi-cycle SYSTEM execute unit (ECALL, EBREAK, MRET, SRET,
// WFI, SFENCE.VMA, Zicsr through an external CSR file).
// Ports:
//   clk  clock
//   rst  synchronous, active-high reset
//   bus  exec_system_mc_if.slave (issue handshake, CSR request/response,
//        TLB flush handshake, registered result)
// Single-cycle ops report one cycle after accept. WFI without a pending
// interrupt parks in WFI_WAIT; a legal SFENCE.VMA parks in FENCE_WAIT with the
// TLB flush request held until acknowledged. flush kills whatever is in flight.
module exec_system_mc #(
  parameter int XLEN      = 64,
  parameter bit HAS_SMODE = 1'b1,
  parameter bit HAS_UMODE = 1'b1
) (
  input logic             clk,
  input logic             rst,
  exec_system_mc_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, WFI_WAIT = 2'd1, FENCE_WAIT = 2'd2} state_e;

  // Everything reported alongside out_valid; held between results.
  typedef struct packed {
    logic            exception;
    logic [3:0]      cause;
    logic            is_xret;
    logic            upd;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] mstatus;
    logic [1:0]      priv;
  } out_t;

  localparam logic [3:0] CAUSE_ILL = 4'd2;
  localparam logic [3:0] CAUSE_BRK = 4'd3;
  localparam logic [3:0] CAUSE_ECU = 4'd8;
  localparam logic [3:0] CAUSE_ECS = 4'd9;
  localparam logic [3:0] CAUSE_ECM = 4'd11;
  localparam logic [1:0] PRV_U = 2'd0;
  localparam logic [1:0] PRV_S = 2'd1;
  localparam logic [1:0] PRV_M = 2'd3;

  state_e          state_q, state_d;
  logic            vld_q, vld_d;
  out_t            out_q, out_d, res;
  logic [XLEN-1:0] vaddr_q, vaddr_d;
  logic [15:0]     asid_q, asid_d;

  logic accept, priv0;
  logic is_csr, is_ecall, is_ebreak, is_mret, is_sret, is_wfi, is_sfence;
  logic sret_ok, wfi_trap, sfence_ok;
  logic [XLEN-1:0] mret_ms, sret_ms;

  assign bus.in_ready = (state_q == IDLE);
  // A flush in the accept cycle cancels the accept outright.
  assign accept = bus.in_valid && (state_q == IDLE) && !bus.flush;

  // Decode. All funct3=0 forms need rd=0; the non-SFENCE ones also need rs1=0.
  always_comb begin
    priv0     = (bus.funct3 == 3'd0) && (bus.rd == 5'd0);
    is_csr    = (bus.funct3 != 3'd0) && (bus.funct3 != 3'd4);
    is_sfence = priv0 && (bus.funct7 == 7'b0001001);
    is_ecall  = priv0 && (bus.rs1 == 5'd0) && (bus.i_imm == 12'h000);
    is_ebreak = priv0 && (bus.rs1 == 5'd0) && (bus.i_imm == 12'h001);
    is_sret   = priv0 && (bus.rs1 == 5'd0) && (bus.i_imm == 12'h102);
    is_wfi    = priv0 && (bus.rs1 == 5'd0) && (bus.i_imm == 12'h105);
    is_mret   = priv0 && (bus.rs1 == 5'd0) && (bus.i_imm == 12'h302);
  end

  // Privilege checks: TSR=bit22, TW=bit21, TVM=bit20.
  always_comb begin
    sret_ok   = HAS_SMODE && (bus.privilege_mode != PRV_U) &&
                !((bus.privilege_mode == PRV_S) && bus.mstatus[22]);
    wfi_trap  = (bus.privilege_mode != PRV_M) && bus.mstatus[21];
    sfence_ok = HAS_SMODE && (bus.privilege_mode != PRV_U) &&
                !((bus.privilege_mode == PRV_S) && bus.mstatus[20]);
  end

  // mstatus after xRET. Without U-mode MPP can only ever hold M.
  always_comb begin
    mret_ms        = bus.mstatus;
    mret_ms[3]     = bus.mstatus[7];
    mret_ms[7]     = 1'b1;
    mret_ms[12:11] = HAS_UMODE ? PRV_U : PRV_M;
    sret_ms        = bus.mstatus;
    sret_ms[1]     = bus.mstatus[5];
    sret_ms[5]     = 1'b1;
    sret_ms[8]     = 1'b0;
  end

  assign bus.csr_valid  = accept && is_csr;
  assign bus.csr_addr   = bus.i_imm;
  assign bus.csr_funct3 = bus.funct3;
  assign bus.csr_uimm   = bus.rs1;
  assign bus.csr_wdata  = bus.rs1_data;

  always_comb begin
    state_d = state_q;
    vld_d   = 1'b0;
    out_d   = out_q;
    vaddr_d = vaddr_q;
    asid_d  = asid_q;
    // Candidate result: clean completion, mstatus/priv side effects held.
    res           = out_q;
    res.exception = 1'b0;
    res.cause     = '0;
    res.is_xret   = 1'b0;
    res.upd       = 1'b0;
    res.result    = '0;

    case (state_q)
      IDLE: if (accept) begin
        vld_d = 1'b1;
        if (is_csr) begin
          res.exception = bus.csr_exception;
          res.cause     = bus.csr_cause;
          res.result    = bus.csr_result;
        end else if (is_ecall) begin
          res.exception = 1'b1;
          case (bus.privilege_mode)
            PRV_U:   res.cause = CAUSE_ECU;
            PRV_S:   res.cause = CAUSE_ECS;
            default: res.cause = CAUSE_ECM;
          endcase
        end else if (is_ebreak) begin
          res.exception = 1'b1;
          res.cause     = CAUSE_BRK;
        end else if (is_mret) begin
          res.is_xret = 1'b1;
          if (bus.privilege_mode == PRV_M) begin
            res.result  = bus.mepc;
            res.upd     = 1'b1;
            res.mstatus = mret_ms;
            res.priv    = bus.mstatus[12:11];
          end else begin
            res.exception = 1'b1;
            res.cause     = CAUSE_ILL;
          end
        end else if (is_sret) begin
          res.is_xret = 1'b1;
          if (sret_ok) begin
            res.result  = bus.sepc;
            res.upd     = 1'b1;
            res.mstatus = sret_ms;
            res.priv    = {1'b0, bus.mstatus[8]};
          end else begin
            res.exception = 1'b1;
            res.cause     = CAUSE_ILL;
          end
        end else if (is_wfi) begin
          if (wfi_trap) begin
            res.exception = 1'b1;
            res.cause     = CAUSE_ILL;
          end else if (!bus.irq_pending) begin
            vld_d   = 1'b0;
            state_d = WFI_WAIT;
          end
        end else if (is_sfence) begin
          if (!sfence_ok) begin
            res.exception = 1'b1;
            res.cause     = CAUSE_ILL;
          end else begin
            vld_d   = 1'b0;
            state_d = FENCE_WAIT;
            vaddr_d = (bus.rs1 != 5'd0) ? bus.rs1_data : '0;
            asid_d  = (bus.rs2 != 5'd0) ? bus.rs2_data[15:0] : 16'd0;
          end
        end else begin
          res.exception = 1'b1;
          res.cause     = CAUSE_ILL;
        end
      end
      // flush outranks the wake-up / ack arriving in the same cycle.
      WFI_WAIT: begin
        if (bus.flush) state_d = IDLE;
        else if (bus.irq_pending) begin
          state_d = IDLE;
          vld_d   = 1'b1;
        end
      end
      FENCE_WAIT: begin
        if (bus.flush) state_d = IDLE;
        else if (bus.tlb_flush_ack) begin
          state_d = IDLE;
          vld_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Fields only move when a result is actually reported.
    if (vld_d) out_d = res;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vld_q   <= 1'b0;
      out_q   <= '0;
      vaddr_q <= '0;
      asid_q  <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      out_q   <= out_d;
      vaddr_q <= vaddr_d;
      asid_q  <= asid_d;
    end
  end

  // The request is a pure function of state, so it stays stable while waiting.
  assign bus.tlb_flush_req   = (state_q == FENCE_WAIT);
  assign bus.tlb_flush_vaddr = vaddr_q;
  assign bus.tlb_flush_asid  = asid_q;

  assign bus.out_valid          = vld_q;
  assign bus.out_exception      = out_q.exception;
  assign bus.out_trap_cause     = out_q.cause;
  assign bus.out_is_xret        = out_q.is_xret;
  assign bus.out_result         = out_q.result;
  assign bus.out_update_mstatus = vld_q && out_q.upd;
  assign bus.out_new_mstatus    = out_q.mstatus;
  assign bus.out_new_priv       = out_q.priv;
endmodule

// File: tb/tb_exec_system_mc.sv
module tb_exec_system_mc;
  localparam int XLEN      = 64;
  localparam bit HAS_SMODE = 1'b1;
  localparam bit HAS_UMODE = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;

  exec_system_mc_if #(.XLEN(XLEN)) bus();

  exec_system_mc #(.XLEN(XLEN), .HAS_SMODE(HAS_SMODE), .HAS_UMODE(HAS_UMODE)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [11:0] imm;
    logic [63:0] rs1_data, rs2_data, ms, mepc, sepc, csr_result;
    logic [1:0]  priv;
    logic        irq, csr_exc;
    logic [3:0]  csr_cause;
  } ins_t;

  typedef struct {
    logic        exc;
    logic [3:0]  cause;
    logic        xret;
    logic        upd;
    logic [63:0] result;
    logic [63:0] ms;
    logic [1:0]  priv;
    int          due;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Reference model: reassemble the 32-bit instruction word and judge it
  // against the architectural rules. kind: 0 immediate, 1 WFI sleep, 2 SFENCE.
  function automatic void model(input ins_t x, output exp_t e, output int kind);
    logic [31:0] w;
    logic [1:0]  p;
    w = {x.imm, x.rs1, x.f3, x.rd, 7'b1110011};
    p = x.priv;
    e = '{exc: 1'b1, cause: 4'd2, xret: 1'b0, upd: 1'b0, result: 64'd0,
          ms: 64'd0, priv: 2'd0, due: 0};
    kind = 0;
    if (w[14:12] != 3'd0 && w[14:12] != 3'd4) begin
      e.exc = x.csr_exc; e.cause = x.csr_cause; e.result = x.csr_result;
      return;
    end
    if (w[14:12] == 3'd4 || w[11:7] != 5'd0) return;
    if (w[31:25] == 7'b0001001) begin
      if (HAS_SMODE && p != 2'd0 && !(p == 2'd1 && x.ms[20])) begin
        e.exc = 1'b0; e.cause = 4'd0; kind = 2;
      end
      return;
    end
    if (w[19:15] != 5'd0) return;
    case (w[31:20])
      12'h000: e.cause = (p == 2'd0) ? 4'd8 : (p == 2'd1) ? 4'd9 : 4'd11;
      12'h001: e.cause = 4'd3;
      12'h302: begin
        e.xret = 1'b1;
        if (p == 2'd3) begin
          e.exc = 1'b0; e.cause = 4'd0; e.upd = 1'b1; e.result = x.mepc;
          e.priv = x.ms[12:11];
          e.ms = (x.ms & ~64'h1888) | (64'(x.ms[7]) << 3) | 64'h80 |
                 (64'(HAS_UMODE ? 0 : 3) << 11);
        end
      end
      12'h102: begin
        e.xret = 1'b1;
        if (HAS_SMODE && p != 2'd0 && !(p == 2'd1 && x.ms[22])) begin
          e.exc = 1'b0; e.cause = 4'd0; e.upd = 1'b1; e.result = x.sepc;
          e.priv = {1'b0, x.ms[8]};
          e.ms = (x.ms & ~64'h122) | (64'(x.ms[5]) << 1) | 64'h20;
        end
      end
      12'h105: begin
        if (!(p != 2'd3 && x.ms[21])) begin
          e.exc = 1'b0; e.cause = 4'd0;
          if (!x.irq) kind = 1;
        end
      end
      default: ;
    endcase
  endfunction

  function automatic ins_t blank(input logic [1:0] priv);
    ins_t x;
    x = '{default: '0};
    x.priv = priv;
    return x;
  endfunction

  task automatic drive(input ins_t x);
    bus.funct3 = x.f3;  bus.rd = x.rd;  bus.rs1 = x.rs1;
    bus.rs2 = x.imm[4:0];  bus.funct7 = x.imm[11:5];  bus.i_imm = x.imm;
    bus.rs1_data = x.rs1_data;  bus.rs2_data = x.rs2_data;
    bus.privilege_mode = x.priv;  bus.mstatus = x.ms;
    bus.mepc = x.mepc;  bus.sepc = x.sepc;  bus.irq_pending = x.irq;
    bus.csr_exception = x.csr_exc;  bus.csr_cause = x.csr_cause;
    bus.csr_result = x.csr_result;
  endtask

  task automatic run_op(input ins_t x, input int dly);
    exp_t e;
    int kind;
    logic [63:0] va;
    logic [15:0] as;
    model(x, e, kind);
    va = (x.rs1 != 5'd0) ? x.rs1_data : 64'd0;
    as = (x.imm[4:0] != 5'd0) ? x.rs2_data[15:0] : 16'd0;
    @(posedge clk); #1;
    drive(x);
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("in_ready_idle", bus.in_ready, 1'b1);
    chk("csr_valid", bus.csr_valid, (x.f3 != 3'd0 && x.f3 != 3'd4));
    if (kind == 0) begin e.due = cyc + 1; sb.push_back(e); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("csr_valid_pulse", bus.csr_valid, 1'b0);
    if (kind == 0) begin
      chk("no_tlb_req", bus.tlb_flush_req, 1'b0);
      chk("ready_after_single", bus.in_ready, 1'b1);
    end else if (kind == 1) begin
      for (int i = 0; i <= dly; i++) begin
        if (i > 0) begin @(posedge clk); #1; @(negedge clk); end
        chk("wfi_not_ready", bus.in_ready, 1'b0);
      end
      @(posedge clk); #1;
      @(negedge clk);
      chk("wfi_not_ready_irq", bus.in_ready, 1'b0);
      bus.irq_pending = 1'b1;
      e.due = cyc + 1; sb.push_back(e);
      @(posedge clk); #1;
      bus.irq_pending = 1'b0;
    end else begin
      for (int i = 0; i <= dly; i++) begin
        if (i > 0) begin @(posedge clk); #1; @(negedge clk); end
        chk("tlb_req_held", bus.tlb_flush_req, 1'b1);
        chk("tlb_vaddr", bus.tlb_flush_vaddr, va);
        chk("tlb_asid", bus.tlb_flush_asid, as);
        chk("fence_not_ready", bus.in_ready, 1'b0);
      end
      bus.tlb_flush_ack = 1'b1;
      e.due = cyc + 1; sb.push_back(e);
      @(posedge clk); #1;
      bus.tlb_flush_ack = 1'b0;
      @(negedge clk);
      chk("tlb_req_drop", bus.tlb_flush_req, 1'b0);
    end
  endtask

  // Monitor: pops the scoreboard whenever a result is presented.
  always @(negedge clk) begin
    if (!rst && mon_en) begin
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_out_valid: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_cycle", 64'(cyc), 64'(e.due));
          chk("out_exception", bus.out_exception, e.exc);
          if (e.exc) chk("out_trap_cause", bus.out_trap_cause, e.cause);
          chk("out_is_xret", bus.out_is_xret, e.xret);
          chk("out_result", bus.out_result, e.result);
          chk("out_update_mstatus", bus.out_update_mstatus, e.upd);
          if (e.upd) begin
            chk("out_new_mstatus", bus.out_new_mstatus, e.ms);
            chk("out_new_priv", bus.out_new_priv, e.priv);
          end
        end
      end else begin
        chk("upd_only_with_valid", bus.out_update_mstatus, 1'b0);
        if (sb.size() > 0 && sb[0].due < cyc) begin
          n_chk++; n_fail++;
          $display("FAIL missing_out_valid: got 0 expected 1 (due cycle %0d)", sb[0].due);
          void'(sb.pop_front());
        end
      end
    end
  end

  function automatic ins_t rnd_ins();
    ins_t x;
    int k;
    logic [2:0] csr_f3 [6];
    csr_f3 = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
    case ($urandom_range(0, 2))
      0: x = blank(2'd0);
      1: x = blank(2'd1);
      default: x = blank(2'd3);
    endcase
    x.ms = {$urandom, $urandom};
    x.mepc = {$urandom, $urandom};  x.sepc = {$urandom, $urandom};
    x.rs1_data = {$urandom, $urandom};  x.rs2_data = {$urandom, $urandom};
    x.irq = 1'($urandom_range(0, 1));
    x.csr_exc = ($urandom_range(0, 3) == 0);
    x.csr_cause = 4'($urandom);
    x.csr_result = {$urandom, $urandom};
    k = $urandom_range(0, 9);
    case (k)
      0, 1: begin
        x.f3 = csr_f3[$urandom_range(0, 5)];
        x.rd = 5'($urandom); x.rs1 = 5'($urandom); x.imm = 12'($urandom);
      end
      2: x.imm = 12'h000;
      3: x.imm = 12'h001;
      4: x.imm = 12'h302;
      5: x.imm = 12'h102;
      6: x.imm = 12'h105;
      7: begin x.imm = {7'b0001001, 5'($urandom)}; x.rs1 = 5'($urandom); end
      8: begin x.f3 = 3'd4; x.imm = 12'($urandom); end
      default: begin
        if ($urandom_range(0, 1) == 1) begin
          x.rd = 5'($urandom_range(1, 31)); x.imm = 12'h302;
        end else begin
          x.imm = 12'h7ff;
        end
      end
    endcase
    return x;
  endfunction

  initial begin
    ins_t x;
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.tlb_flush_ack = 1'b0;
    drive(blank(2'd3));
    repeat (3) @(posedge clk);
    #1;
    // reset state
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_exception", bus.out_exception, 1'b0);
    chk("rst_out_is_xret", bus.out_is_xret, 1'b0);
    chk("rst_out_update", bus.out_update_mstatus, 1'b0);
    chk("rst_tlb_req", bus.tlb_flush_req, 1'b0);
    chk("rst_csr_valid", bus.csr_valid, 1'b0);
    chk("rst_cause", bus.out_trap_cause, 4'd0);
    chk("rst_result", bus.out_result, 64'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // MRET in M: MPP=01, MPIE=1
    x = blank(2'd3); x.imm = 12'h302; x.ms = 64'h880; x.mepc = 64'h8000_0040;
    run_op(x, 0);
    // SRET in S with TSR
    x = blank(2'd1); x.imm = 12'h102; x.ms = 64'h40_0000;
    run_op(x, 0);
    // ECALL in U
    x = blank(2'd0); x.imm = 12'h000;
    run_op(x, 0);
    // WFI in M, five idle cycles before the interrupt
    x = blank(2'd3); x.imm = 12'h105;
    run_op(x, 4);
    // SFENCE.VMA with ack in the third request cycle
    x = blank(2'd3); x.imm = {7'b0001001, 5'd0}; x.rs1 = 5'd7; x.rs1_data = 64'h1000;
    run_op(x, 2);
    // same op in S with TVM: illegal, no request
    x.priv = 2'd1; x.ms = 64'h10_0000;
    run_op(x, 0);
    // CSRRW with and without a CSR exception
    x = blank(2'd3); x.f3 = 3'd1; x.rd = 5'd3; x.rs1 = 5'd4; x.imm = 12'h300;
    x.csr_exc = 1'b1; x.csr_cause = 4'd2;
    run_op(x, 0);
    x.csr_exc = 1'b0; x.csr_cause = 4'd0; x.csr_result = 64'h55;
    run_op(x, 0);
    // SFENCE with ack in the very first request cycle
    x = blank(2'd1); x.imm = {7'b0001001, 5'd9}; x.rs1 = 5'd0; x.rs2_data = 64'hABCD_1234;
    run_op(x, 0);

    // flush in the accept cycle cancels the op
    @(posedge clk); #1;
    x = blank(2'd3); x.f3 = 3'd2; x.rd = 5'd1; x.imm = 12'h340;
    drive(x); bus.in_valid = 1'b1; bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_accept_csr_valid", bus.csr_valid, 1'b0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_accept_no_out", bus.out_valid, 1'b0);

    // flush in WFI_WAIT beats a simultaneous interrupt
    @(posedge clk); #1;
    x = blank(2'd3); x.imm = 12'h105;
    drive(x); bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("wfi_wait_entered", bus.in_ready, 1'b0);
    @(posedge clk); #1;
    bus.flush = 1'b1; bus.irq_pending = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.irq_pending = 1'b0;
    @(negedge clk);
    chk("wfi_flush_no_out", bus.out_valid, 1'b0);
    chk("wfi_flush_ready", bus.in_ready, 1'b1);

    // reset during FENCE_WAIT
    @(posedge clk); #1;
    x = blank(2'd3); x.imm = {7'b0001001, 5'd1}; x.rs1 = 5'd2; x.rs1_data = 64'h2000;
    drive(x); bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("fence_req_before_rst", bus.tlb_flush_req, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_fence_req", bus.tlb_flush_req, 1'b0);
    chk("rst_fence_ready", bus.in_ready, 1'b1);
    chk("rst_fence_no_out", bus.out_valid, 1'b0);

    // randomized traffic
    for (int n = 0; n < 200; n++) begin
      x = rnd_ins();
      run_op(x, $urandom_range(0, 4));
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: got no completion expected $finish before 2ms");
    $fatal(1, "timeout");
  end
endmodule
